// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the FIFO write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 32;
  localparam int PTR_W_DEF     = 8;
  localparam int MAX_BURST_DEF = 16;

  // First requester at or after rr_ptr, wrapping modulo n (n up to 8). Scanning from the
  // farthest offset down leaves the nearest hit as the result.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] rr_ptr,
                                         input int n);
    logic [2:0] idx;
    rr_pick = rr_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = 3'((int'(rr_ptr) + i) % n);
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; master = environment, slave = arbiter.
interface fifo_wr_arbiter_if
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int PTR_W = PTR_W_DEF
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         last;
  logic [NREQ*DW-1:0]      data;
  logic [NREQ-1:0]         gnt;
  logic                    winc;
  logic [DW-1:0]           wdata;
  logic                    wfull;
  logic [PTR_W:0]          wq2_rptr;
  logic [PTR_W:0]          w_ptr;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;

  modport master (output req, last, data, wfull, wq2_rptr, w_ptr,
                  input  gnt, winc, wdata, busy, owner);
  modport slave  (input  req, last, data, wfull, wq2_rptr, w_ptr,
                  output gnt, winc, wdata, busy, owner);
endinterface

// File: rtl/fifo_wr_arbiter_gray2bin.sv
// Combinational Gray-to-binary converter for FIFO pointers.
module gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(gray >> i);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_SPACE_EN to hold off grants until a full MAX_BURST fits in the FIFO.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int PTR_W     = PTR_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic              wclk,
  input logic              wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state;
  logic [OW-1:0] owner_q, rr_q, owner_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    pick;
  logic          beat, rel, space_ok;

`ifdef FIFO_WR_ARB_SPACE_EN
  localparam logic [PTR_W+1:0] DEPTH = (PTR_W+2)'(2 ** PTR_W);
  logic [PTR_W:0]   wbin, rbin, fill;
  logic [PTR_W+1:0] free;

  gray2bin #(.W(PTR_W + 1)) u_wbin (.gray(bus.w_ptr),    .bin(wbin));
  gray2bin #(.W(PTR_W + 1)) u_rbin (.gray(bus.wq2_rptr), .bin(rbin));

  // Pointer difference wraps naturally in PTR_W+1 bits.
  assign fill     = wbin - rbin;
  assign free     = DEPTH - {1'b0, fill};
  assign space_ok = free >= (PTR_W+2)'(MAX_BURST);
`else
  assign space_ok = 1'b1;
`endif

  assign pick      = rr_pick(8'(bus.req), 3'(rr_q), NREQ);
  assign beat      = (state == ARB_BURST) && bus.req[owner_q] && !bus.wfull;
  assign rel       = beat && (bus.last[owner_q] || cnt == CW'(MAX_BURST - 1));
  assign owner_nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    bus.gnt          = '0;
    bus.gnt[owner_q] = beat;
  end

  assign bus.winc  = beat;
  assign bus.wdata = bus.data[owner_q*DW +: DW];
  assign bus.busy  = (state == ARB_BURST);
  assign bus.owner = owner_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state   <= ARB_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (|bus.req && space_ok) begin
          state   <= ARB_BURST;
          owner_q <= pick[OW-1:0];
          cnt     <= '0;
        end
        ARB_BURST: if (beat) begin
          cnt <= cnt + 1'b1;
          if (rel) begin
            state <= ARB_IDLE;
            rr_q  <= owner_nxt;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_no_write_when_full: assert property (@(posedge wclk) disable iff (!wrst_n)
    !(bus.winc && bus.wfull));
  a_gnt_onehot: assert property (@(posedge wclk) disable iff (!wrst_n)
    $onehot0(bus.gnt) && (bus.winc == |bus.gnt));

endmodule
